chunked_add_sub: RTL and testbench

Multi-cycle, parametrised two's-complement adder/subtractor for the calculator datapath. It replaces the single-cycle ripple adder on wide operands. Each operation is processed CHUNK_WIDTH bits per cycle, least significant chunk first, with a registered carry between chunks. Valid/ready handshakes sit on both sides, between the operand latch and the result/display stage. It adds a subtract mode, status flags and optional saturation.

---
 rtl/chunked_add_sub.sv | 139 +++++++++++++
 tb/tb_chunked_add_sub.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/chunked_add_sub.sv
// Multi-cycle two's-complement adder/subtractor, CHUNK_WIDTH bits per cycle, LS chunk first.
// Optional result saturation on signed overflow: define CHUNKED_ADD_SUB_SATURATE_EN.
module chunked_add_sub #(
  parameter int unsigned DATA_WIDTH  = 16,
  parameter int unsigned CHUNK_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  input  logic                  op_sub,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] result,
  output logic                  carry_out,
  output logic                  overflow,
  output logic                  zero
);

  localparam int unsigned NUM_CHUNKS = DATA_WIDTH / CHUNK_WIDTH;
  localparam int unsigned CNT_W      = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;
  localparam int unsigned MSB        = DATA_WIDTH - 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_CHUNKS - 1);

  generate
    if ((DATA_WIDTH % CHUNK_WIDTH) != 0) begin : g_width_check
      $error("chunked_add_sub: DATA_WIDTH must be a multiple of CHUNK_WIDTH");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [DATA_WIDTH-1:0] r_a;
  logic [DATA_WIDTH-1:0] r_b;
  logic [DATA_WIDTH-1:0] r_acc;
  logic                  r_carry;
  logic [CNT_W-1:0]      r_cnt;
  logic                  r_in_ready;
  logic                  r_out_valid;
  logic [DATA_WIDTH-1:0] r_result;
  logic                  r_carry_out;
  logic                  r_overflow;
  logic                  r_zero;

  logic [31:0]            w_bit_pos;
  logic [CHUNK_WIDTH-1:0] w_a_chunk;
  logic [CHUNK_WIDTH-1:0] w_b_chunk;
  logic [CHUNK_WIDTH:0]   w_chunk_ext;
  logic [DATA_WIDTH-1:0]  w_full;
  logic [DATA_WIDTH-1:0]  w_final;
  logic                   w_ovf;
  logic                   w_last;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE:    if (in_valid)  w_state_nxt = RUN;
      RUN:     if (w_last)    w_state_nxt = DONE;
      DONE:    if (out_ready) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // One chunk of A + B' + carry; w_full merges it into the partial result
  always_comb begin
    w_last      = (r_cnt == LAST_CNT);
    w_bit_pos   = 32'(r_cnt) * CHUNK_WIDTH;
    w_a_chunk   = CHUNK_WIDTH'(r_a >> w_bit_pos);
    w_b_chunk   = CHUNK_WIDTH'(r_b >> w_bit_pos);
    w_chunk_ext = {1'b0, w_a_chunk} + {1'b0, w_b_chunk} + (CHUNK_WIDTH + 1)'(r_carry);
    w_full      = r_acc | (DATA_WIDTH'(w_chunk_ext[CHUNK_WIDTH-1:0]) << w_bit_pos);
    w_ovf       = (r_a[MSB] == r_b[MSB]) & (w_full[MSB] != r_a[MSB]);
`ifdef CHUNKED_ADD_SUB_SATURATE_EN
    if (w_ovf) w_final = r_a[MSB] ? {1'b1, {(DATA_WIDTH-1){1'b0}}} : {1'b0, {(DATA_WIDTH-1){1'b1}}};
    else       w_final = w_full;
`else
    w_final     = w_full;
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a         <= '0;
      r_b         <= '0;
      r_acc       <= '0;
      r_carry     <= 1'b0;
      r_cnt       <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_result    <= '0;
      r_carry_out <= 1'b0;
      r_overflow  <= 1'b0;
      r_zero      <= 1'b0;
    end else begin
      r_in_ready  <= (w_state_nxt == IDLE);
      r_out_valid <= (w_state_nxt == DONE);
      unique case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_a     <= a;
            r_b     <= op_sub ? ~b : b;
            r_carry <= op_sub;
            r_cnt   <= '0;
            r_acc   <= '0;
          end
        end
        RUN: begin
          r_acc   <= w_full;
          r_carry <= w_chunk_ext[CHUNK_WIDTH];
          r_cnt   <= r_cnt + CNT_W'(1);
          if (w_last) begin
            r_result    <= w_final;
            r_carry_out <= w_chunk_ext[CHUNK_WIDTH];
            r_overflow  <= w_ovf;
            r_zero      <= (w_final == '0);
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign result    = r_result;
  assign carry_out = r_carry_out;
  assign overflow  = r_overflow;
  assign zero      = r_zero;

endmodule

// File: tb/tb_chunked_add_sub.sv
// Directed bench for chunked_add_sub: arithmetic reference model plus a per-cycle output comparator.
module tb_chunked_add_sub;

  localparam int unsigned DW = 16;
  localparam int unsigned CW = 4;
  localparam int unsigned NC = DW / CW;

  typedef struct packed {
    logic [DW-1:0] res;
    logic          c;
    logic          v;
    logic          z;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] a;
  logic [DW-1:0] b;
  logic          op_sub;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] result;
  logic          carry_out;
  logic          overflow;
  logic          zero;

  int   n_checks = 0;
  int   n_errors = 0;
  exp_t exp_cur;

`ifdef CHUNKED_ADD_SUB_SATURATE_EN
  localparam logic [DW-1:0] OVF_ADD_RES = 16'h7FFF;
  localparam logic [DW-1:0] OVF_SUB_RES = 16'h8000;
`else
  localparam logic [DW-1:0] OVF_ADD_RES = 16'h8000;
  localparam logic [DW-1:0] OVF_SUB_RES = 16'h7FFF;
`endif

  chunked_add_sub #(.DATA_WIDTH(DW), .CHUNK_WIDTH(CW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .op_sub(op_sub), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .carry_out(carry_out), .overflow(overflow), .zero(zero)
  );

  always #5 clk = ~clk;

  task automatic chk1(input string name, input logic act, input logic expv);
    n_checks++;
    if (act !== expv) begin
      n_errors++;
      $display("FAIL %s actual=%b expected=%b at %0t", name, act, expv, $time);
    end
  endtask

  task automatic chk16(input string name, input logic [DW-1:0] act, input logic [DW-1:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, expv, $time);
    end
  endtask

  // Reference: plain integer arithmetic, signed range test for overflow
  function automatic exp_t model(input logic [DW-1:0] ma, input logic [DW-1:0] mb, input logic msub);
    exp_t e;
    int   s;
    if (msub) begin
      e.res = ma - mb;
      e.c   = (ma >= mb);
      s     = int'($signed(ma)) - int'($signed(mb));
    end else begin
      e.res = ma + mb;
      e.c   = ((32'(ma) + 32'(mb)) > 32'hFFFF);
      s     = int'($signed(ma)) + int'($signed(mb));
    end
    e.v = (s > 32767) || (s < -32768);
`ifdef CHUNKED_ADD_SUB_SATURATE_EN
    if (e.v) e.res = (s > 0) ? 16'h7FFF : 16'h8000;
`endif
    e.z = (e.res == '0);
    return e;
  endfunction

  // Every valid output cycle (including stalls) must match the model
  always @(negedge clk) begin
    if (!rst && out_valid) begin
      chk16("cmp_result", result, exp_cur.res);
      chk1("cmp_carry", carry_out, exp_cur.c);
      chk1("cmp_overflow", overflow, exp_cur.v);
      chk1("cmp_zero", zero, exp_cur.z);
      chk1("cmp_in_ready_low", in_ready, 1'b0);
    end
  end

  task automatic run_op(input logic [DW-1:0] ta, input logic [DW-1:0] tb, input logic tsub,
                        input int stall, input logic [DW-1:0] lit_res,
                        input logic lit_c, input logic lit_v, input logic lit_z);
    exp_t m;
    m = model(ta, tb, tsub);
    chk16("model_res", m.res, lit_res);
    chk1("model_c", m.c, lit_c);
    chk1("model_v", m.v, lit_v);
    chk1("model_z", m.z, lit_z);
    exp_cur   = m;
    out_ready = (stall == 0);
    a = ta; b = tb; op_sub = tsub; in_valid = 1'b1;
    chk1("in_ready_idle", in_ready, 1'b1);
    @(posedge clk); #1;
    in_valid = 1'b0; a = 16'hDEAD; b = 16'hBEEF; op_sub = ~tsub;
    for (int k = 1; k <= int'(NC); k++) begin
      @(posedge clk); #1;
      chk1("latency_out_valid", out_valid, (k == int'(NC)));
      chk1("run_in_ready", in_ready, 1'b0);
    end
    chk16("dut_res_literal", result, lit_res);
    chk1("dut_c_literal", carry_out, lit_c);
    chk1("dut_v_literal", overflow, lit_v);
    chk1("dut_z_literal", zero, lit_z);
    for (int s = 0; s < stall; s++) begin
      chk1("stall_out_valid", out_valid, 1'b1);
      chk16("stall_result", result, lit_res);
      in_valid = (s == 1);
      a = 16'h5555; b = 16'h3333; op_sub = 1'b1;
      @(posedge clk); #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    chk1("pre_hs_out_valid", out_valid, 1'b1);
    @(posedge clk); #1;
    chk1("post_hs_out_valid", out_valid, 1'b0);
    chk1("post_hs_in_ready", in_ready, 1'b1);
    out_ready = 1'b0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk1({tag, "_in_ready"}, in_ready, 1'b1);
    chk1({tag, "_out_valid"}, out_valid, 1'b0);
    chk16({tag, "_result"}, result, 16'h0000);
    chk1({tag, "_carry"}, carry_out, 1'b0);
    chk1({tag, "_overflow"}, overflow, 1'b0);
    chk1({tag, "_zero"}, zero, 1'b0);
  endtask

  initial begin
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; op_sub = 1'b0;
    exp_cur = '0;
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk_reset_outputs("reset");
    rst = 1'b0;
    @(posedge clk); #1;

    run_op(16'h1234, 16'h0FFF, 1'b0, 0, 16'h2233, 1'b0, 1'b0, 1'b0);
    run_op(16'h0005, 16'h0007, 1'b1, 0, 16'hFFFE, 1'b0, 1'b0, 1'b0);
    run_op(16'h0007, 16'h0005, 1'b1, 0, 16'h0002, 1'b1, 1'b0, 1'b0);
    run_op(16'hFFFF, 16'h0001, 1'b0, 0, 16'h0000, 1'b1, 1'b0, 1'b1);
    run_op(16'h7FFF, 16'h0001, 1'b0, 0, OVF_ADD_RES, 1'b0, 1'b1, 1'b0);
    run_op(16'h8000, 16'h0001, 1'b1, 0, OVF_SUB_RES, 1'b1, 1'b1, 1'b0);
    run_op(16'h1234, 16'h1234, 1'b1, 0, 16'h0000, 1'b1, 1'b0, 1'b1);
    run_op(16'h00FF, 16'h0F01, 1'b0, 5, 16'h1000, 1'b0, 1'b0, 1'b0);

    // Abort in the second RUN cycle
    a = 16'h4321; b = 16'h1111; op_sub = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk_reset_outputs("abort");
    for (int k = 0; k < int'(NC); k++) begin
      @(posedge clk); #1;
      chk1("abort_no_out_valid", out_valid, 1'b0);
    end
    rst = 1'b0;
    @(posedge clk); #1;
    chk1("abort_idle_no_out_valid", out_valid, 1'b0);
    chk16("abort_result_held_zero", result, 16'h0000);
    run_op(16'h0001, 16'h0002, 1'b0, 0, 16'h0003, 1'b0, 1'b0, 1'b0);

    repeat (2) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
